// File: rtl/pd_dw_nr_pkg.sv
// Shared types and constants for the downlink NR symbol scheduler: rate config,
// CP/FFT constants, the select decoder and the scheduler FSM states.
package pd_dw_nr_pkg;

  localparam int CNT_W = 15;

  localparam int N_1K = 1024;
  localparam int N_2K = 2048;
  localparam int N_4K = 4096;

  localparam int CP_NORM_1K = 72;
  localparam int CP_LONG_1K = 88;
  localparam int CP_NORM_2K = 144;
  localparam int CP_LONG_2K = 176;
  localparam int CP_NORM_4K = 288;
  localparam int CP_LONG_4K = 352;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [1:0]       fft_sel;
    logic [4:0]       ant_num;
    logic [8:0]       cp_norm;
    logic [8:0]       cp_long;
    logic [CNT_W-1:0] d_norm;
    logic [CNT_W-1:0] d_long;
  } cfg_t;

  // Symbol duration in 491.52 MHz clocks is (N + CP) * interleave.
  function automatic cfg_t make_cfg(input logic [1:0] fft, input logic [4:0] ant,
                                    input int n, input int cpn, input int cpl);
    cfg_t c;
    c.fft_sel = fft;
    c.ant_num = ant;
    c.cp_norm = 9'(cpn);
    c.cp_long = 9'(cpl);
    c.d_norm  = CNT_W'((n + cpn) * int'(ant));
    c.d_long  = CNT_W'((n + cpl) * int'(ant));
    return c;
  endfunction

  function automatic cfg_t sel_decode(input logic [3:0] sel);
    cfg_t c;
    case (sel)
      4'd2, 4'd3:       c = make_cfg(2'd0, 5'd16, N_1K, CP_NORM_1K, CP_LONG_1K);
      4'd4, 4'd5, 4'd6: c = make_cfg(2'd1, 5'd8,  N_2K, CP_NORM_2K, CP_LONG_2K);
      default:          c = make_cfg(2'd2, 5'd4,  N_4K, CP_NORM_4K, CP_LONG_4K);
    endcase
    return c;
  endfunction

  localparam cfg_t CFG_DEFAULT = sel_decode(4'd0);

endpackage

// File: rtl/pd_dw_nr_sym_sched_if.sv
// Scheduler-to-engine bus: frame/rate inputs, descriptor request handshake,
// status flags and the FSM state for observation.
interface pd_dw_nr_sym_sched_if #(parameter int SLOT_W = 5);
  import pd_dw_nr_pkg::*;

  logic [3:0]        i_sel;
  logic              i_fram;
  logic              i_ack;
  logic              i_done;
  logic              i_ovf_clr;
  logic              o_req;
  logic [SLOT_W-1:0] o_slot_idx;
  logic [3:0]        o_sym_idx;
  logic [1:0]        o_fft_sel;
  logic [8:0]        o_cp_len;
  logic [4:0]        o_ant_num;
  logic              o_sym_start;
  logic              o_busy;
  logic              o_ovf;
  sched_state_t      dbg_state;

  // Handshake: o_req and the descriptor are stable until the cycle with
  // o_req & i_ack (transfer); the engine then pulses i_done once when finished.
  modport master (
    input  i_sel, i_fram, i_ack, i_done, i_ovf_clr,
    output o_req, o_slot_idx, o_sym_idx, o_fft_sel, o_cp_len, o_ant_num,
    output o_sym_start, o_busy, o_ovf, dbg_state
  );

  modport slave (
    output i_sel, i_fram, i_ack, i_done, i_ovf_clr,
    input  o_req, o_slot_idx, o_sym_idx, o_fft_sel, o_cp_len, o_ant_num,
    input  o_sym_start, o_busy, o_ovf, dbg_state
  );

endinterface

// File: rtl/pd_dw_nr_sym_timer.sv
// Symbol/slot timing: free-running cycle, symbol and slot counters restarted by
// the frame pulse; symbol 0 of each slot uses the long-CP duration.
module pd_dw_nr_sym_timer
  import pd_dw_nr_pkg::*;
#(
  parameter int SLOT_NUM = 20,
  parameter int SLOT_W   = 5,
  parameter int SYM_NUM  = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fram,
  input  logic [CNT_W-1:0]  d_norm,
  input  logic [CNT_W-1:0]  d_long,
  output logic              sym_start,
  output logic [SLOT_W-1:0] slot,
  output logic [3:0]        sym
);

  logic             run;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] d_cur;

  assign d_cur     = (sym == 4'd0) ? d_long : d_norm;
  assign sym_start = run & (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run  <= 1'b0;
      cnt  <= '0;
      sym  <= '0;
      slot <= '0;
    end else if (fram) begin
      run  <= 1'b1;
      cnt  <= '0;
      sym  <= '0;
      slot <= '0;
    end else if (run) begin
      if (cnt == d_cur - CNT_W'(1)) begin
        cnt <= '0;
        if (sym == 4'(SYM_NUM - 1)) begin
          sym <= '0;
          if (slot == SLOT_W'(SLOT_NUM - 1)) slot <= '0;
          else                               slot <= slot + SLOT_W'(1);
        end else begin
          sym <= sym + 4'd1;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pd_dw_nr_sym_sched.sv
// Downlink NR symbol scheduler: latches the rate config on the frame pulse and
// issues one descriptor per symbol boundary with a single-entry pending slot.
module pd_dw_nr_sym_sched
  import pd_dw_nr_pkg::*;
#(
  parameter int SLOT_NUM = 20,
  parameter int SLOT_W   = 5,
  parameter int SYM_NUM  = 14
) (
  input logic                  sys_clk,
  input logic                  sys_rst,
  pd_dw_nr_sym_sched_if.master bus
);

  typedef struct packed {
    logic [SLOT_W-1:0] slot;
    logic [3:0]        sym;
    logic [1:0]        fft_sel;
    logic [8:0]        cp_len;
    logic [4:0]        ant_num;
  } desc_t;

  cfg_t         cfg;
  sched_state_t state, state_n;
  desc_t        odesc, odesc_n, pdesc, pdesc_n, ndesc;
  logic         pend, pend_n;
  logic         ovf, ovf_set;
  logic         b;
  logic [SLOT_W-1:0] t_slot;
  logic [3:0]        t_sym;

  pd_dw_nr_sym_timer #(
    .SLOT_NUM(SLOT_NUM),
    .SLOT_W  (SLOT_W),
    .SYM_NUM (SYM_NUM)
  ) u_timer (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .fram     (bus.i_fram),
    .d_norm   (cfg.d_norm),
    .d_long   (cfg.d_long),
    .sym_start(b),
    .slot     (t_slot),
    .sym      (t_sym)
  );

  // Rate select only matters on the frame pulse; it is ignored otherwise.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)         cfg <= CFG_DEFAULT;
    else if (bus.i_fram) cfg <= sel_decode(bus.i_sel);
  end

  always_comb begin
    ndesc.slot    = t_slot;
    ndesc.sym     = t_sym;
    ndesc.fft_sel = cfg.fft_sel;
    ndesc.cp_len  = (t_sym == 4'd0) ? cfg.cp_long : cfg.cp_norm;
    ndesc.ant_num = cfg.ant_num;
  end

  always_comb begin
    state_n = state;
    odesc_n = odesc;
    pdesc_n = pdesc;
    pend_n  = pend;
    ovf_set = 1'b0;
    if (bus.i_fram) begin
      state_n = ST_IDLE;
      pend_n  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (b) begin
            odesc_n = ndesc;
            state_n = ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.i_ack) begin
            state_n = ST_BUSY;
            if (b) begin
              pdesc_n = ndesc;
              pend_n  = 1'b1;
              ovf_set = pend;
            end
          end else if (b) begin
            odesc_n = ndesc;
            ovf_set = 1'b1;
          end
        end
        ST_BUSY: begin
          // A boundary coinciding with done is handled as arriving just after it.
          if (bus.i_done) begin
            if (pend) begin
              odesc_n = pdesc;
              state_n = ST_REQ;
              pend_n  = b;
              if (b) pdesc_n = ndesc;
            end else if (b) begin
              odesc_n = ndesc;
              state_n = ST_REQ;
            end else begin
              state_n = ST_IDLE;
            end
          end else if (b) begin
            pdesc_n = ndesc;
            pend_n  = 1'b1;
            ovf_set = pend;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= ST_IDLE;
      odesc <= '0;
      pdesc <= '0;
      pend  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      odesc <= odesc_n;
      pdesc <= pdesc_n;
      pend  <= pend_n;
      if (ovf_set)            ovf <= 1'b1;
      else if (bus.i_ovf_clr) ovf <= 1'b0;
    end
  end

  assign bus.o_req       = (state == ST_REQ);
  assign bus.o_busy      = (state == ST_BUSY);
  assign bus.o_slot_idx  = odesc.slot;
  assign bus.o_sym_idx   = odesc.sym;
  assign bus.o_fft_sel   = odesc.fft_sel;
  assign bus.o_cp_len    = odesc.cp_len;
  assign bus.o_ant_num   = odesc.ant_num;
  assign bus.o_sym_start = b;
  assign bus.o_ovf       = ovf;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_pd_dw_nr_sym_sched.sv
// Directed bench for pd_dw_nr_sym_sched: a cycle-indexed vector table over one
// frame (2 slots x 2 symbols) plus resync and async-reset sequences.
module tb_pd_dw_nr_sym_sched;
  import pd_dw_nr_pkg::*;

  localparam int SLOT_W = 5;

  typedef logic [28:0] obs_t;
  typedef logic [24:0] desc_t;

  typedef struct {
    int   rel;
    logic ack;
    logic done;
    logic clr;
    obs_t exp;
  } vec_t;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rel;
  desc_t exp_q[$];
  vec_t  vecs[21];

  pd_dw_nr_sym_sched_if #(.SLOT_W(SLOT_W)) bus ();

  pd_dw_nr_sym_sched #(
    .SLOT_NUM(2),
    .SLOT_W  (SLOT_W),
    .SYM_NUM (2)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  // Clock / reset
  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic desc_t dpack(int slot, int sym, int fft, int cp, int ant);
    return {5'(slot), 4'(sym), 2'(fft), 9'(cp), 5'(ant)};
  endfunction

  function automatic obs_t pack(bit st, bit req, bit busy, bit ovf,
                                int slot, int sym, int fft, int cp, int ant);
    return {st, req, busy, ovf, dpack(slot, sym, fft, cp, ant)};
  endfunction

  function automatic obs_t obs_now();
    return {bus.o_sym_start, bus.o_req, bus.o_busy, bus.o_ovf, bus.o_slot_idx,
            bus.o_sym_idx, bus.o_fft_sel, bus.o_cp_len, bus.o_ant_num};
  endfunction

  function automatic vec_t mk(int r, bit a, bit d, bit c, bit st, bit req, bit busy,
                              bit ovf, int slot, int sym, int fft, int cp, int ant);
    vec_t v;
    v.rel  = r;
    v.ack  = a;
    v.done = d;
    v.clr  = c;
    v.exp  = pack(st, req, busy, ovf, slot, sym, fft, cp, ant);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.i_fram    = 1'b0;
    bus.i_ack     = 1'b0;
    bus.i_done    = 1'b0;
    bus.i_ovf_clr = 1'b0;
  endtask

  // Scoreboard: every accepted descriptor must match the next expected one.
  always @(negedge sys_clk) begin
    if (!sys_rst && bus.o_req === 1'b1 && bus.i_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_extra: unexpected accept 0x%0h, want none", obs_now());
      end else begin
        check("sb_accept", 32'({bus.o_slot_idx, bus.o_sym_idx, bus.o_fft_sel,
                                bus.o_cp_len, bus.o_ant_num}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    bus.i_sel = 4'd0;
    drive_idle();

    // Frame with sel=2 (1024/x16); timeline rel = cycles since the frame edge.
    vecs[0]  = mk(1,     1, 1, 0,  1, 0, 0, 0,  0, 0, 0, 0,  0);
    vecs[1]  = mk(2,     0, 1, 0,  0, 1, 0, 0,  0, 0, 0, 88, 16);
    vecs[2]  = mk(3,     0, 0, 0,  0, 1, 0, 0,  0, 0, 0, 88, 16);
    vecs[3]  = mk(17792, 0, 0, 0,  0, 1, 0, 0,  0, 0, 0, 88, 16);
    vecs[4]  = mk(17793, 0, 0, 0,  1, 1, 0, 0,  0, 0, 0, 88, 16);
    vecs[5]  = mk(17794, 0, 0, 1,  0, 1, 0, 1,  0, 1, 0, 72, 16);
    vecs[6]  = mk(17795, 0, 0, 0,  0, 1, 0, 0,  0, 1, 0, 72, 16);
    vecs[7]  = mk(17796, 1, 0, 0,  0, 1, 0, 0,  0, 1, 0, 72, 16);
    vecs[8]  = mk(17797, 1, 0, 0,  0, 0, 1, 0,  0, 1, 0, 72, 16);
    vecs[9]  = mk(35328, 0, 0, 0,  0, 0, 1, 0,  0, 1, 0, 72, 16);
    vecs[10] = mk(35329, 0, 0, 0,  1, 0, 1, 0,  0, 1, 0, 72, 16);
    vecs[11] = mk(35330, 0, 0, 0,  0, 0, 1, 0,  0, 1, 0, 72, 16);
    vecs[12] = mk(53121, 0, 0, 1,  1, 0, 1, 0,  0, 1, 0, 72, 16);
    vecs[13] = mk(53122, 0, 0, 1,  0, 0, 1, 1,  0, 1, 0, 72, 16);
    vecs[14] = mk(53123, 0, 0, 0,  0, 0, 1, 0,  0, 1, 0, 72, 16);
    vecs[15] = mk(70656, 0, 0, 0,  0, 0, 1, 0,  0, 1, 0, 72, 16);
    vecs[16] = mk(70657, 0, 1, 0,  1, 0, 1, 0,  0, 1, 0, 72, 16);
    vecs[17] = mk(70658, 1, 0, 0,  0, 1, 0, 0,  1, 1, 0, 72, 16);
    vecs[18] = mk(70659, 0, 0, 0,  0, 0, 1, 0,  1, 1, 0, 72, 16);
    vecs[19] = mk(70670, 0, 1, 0,  0, 0, 1, 0,  1, 1, 0, 72, 16);
    vecs[20] = mk(70671, 0, 0, 0,  0, 1, 0, 0,  0, 0, 0, 88, 16);

    exp_q.push_back(dpack(0, 1, 0, 72, 16));
    exp_q.push_back(dpack(1, 1, 0, 72, 16));
    exp_q.push_back(dpack(0, 0, 1, 176, 8));

    // Reset state
    repeat (3) step();
    check("reset_outputs", 32'(obs_now()), 32'(pack(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    check("reset_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    sys_rst = 1'b0;
    repeat (2) step();

    // Frame pulse, then change i_sel mid-frame (must not affect anything).
    bus.i_sel  = 4'd2;
    bus.i_fram = 1'b1;
    step();
    bus.i_fram = 1'b0;
    bus.i_sel  = 4'd5;
    rel = 1;

    for (int i = 0; i < 21; i++) begin
      while (rel < vecs[i].rel) begin
        step();
        rel++;
      end
      check($sformatf("vec%0d_rel%0d", i, vecs[i].rel), 32'(obs_now()), 32'(vecs[i].exp));
      bus.i_ack     = vecs[i].ack;
      bus.i_done    = vecs[i].done;
      bus.i_ovf_clr = vecs[i].clr;
      step();
      rel++;
      drive_idle();
    end

    // Mid-symbol resync with a request outstanding, new rate 2048/x8.
    bus.i_sel  = 4'd5;
    bus.i_fram = 1'b1;
    step();
    bus.i_fram = 1'b0;
    bus.i_sel  = 4'd0;
    check("resync_start", 32'(obs_now()), 32'(pack(1, 0, 0, 0, 0, 0, 0, 88, 16)));
    step();
    check("resync_req", 32'(obs_now()), 32'(pack(0, 1, 0, 0, 0, 0, 1, 176, 8)));
    bus.i_ack = 1'b1;
    step();
    bus.i_ack = 1'b0;
    check("resync_busy", 32'(obs_now()), 32'(pack(0, 0, 1, 0, 0, 0, 1, 176, 8)));
    bus.i_done = 1'b1;
    step();
    bus.i_done = 1'b0;
    check("resync_idle", 32'(obs_now()), 32'(pack(0, 0, 0, 0, 0, 0, 1, 176, 8)));
    bus.i_done = 1'b1;
    bus.i_ack  = 1'b1;
    step();
    drive_idle();
    check("idle_ignore", 32'(obs_now()), 32'(pack(0, 0, 0, 0, 0, 0, 1, 176, 8)));

    // New frame at 4096/x4, then asynchronous reset while requesting.
    bus.i_sel  = 4'd8;
    bus.i_fram = 1'b1;
    step();
    bus.i_fram = 1'b0;
    check("sel8_start", 32'(obs_now()), 32'(pack(1, 0, 0, 0, 0, 0, 1, 176, 8)));
    step();
    check("sel8_req", 32'(obs_now()), 32'(pack(0, 1, 0, 0, 0, 0, 2, 352, 4)));
    #2;
    sys_rst = 1'b1;
    #1;
    check("async_rst", 32'(obs_now()), 32'(pack(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    step();
    check("rst_hold", 32'(obs_now()), 32'(pack(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    sys_rst = 1'b0;
    step();
    check("post_rst", 32'(obs_now()), 32'(pack(0, 0, 0, 0, 0, 0, 0, 0, 0)));

    check("sb_drained", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pd_dw_nr_sym_sched.md
Name: pd_dw_nr_sym_sched

Overview:
Downlink NR symbol scheduler.
- Tracks OFDM symbol and slot timing at 491.52 MHz from the frame pulse and the sample-rate select.
- At each symbol boundary it issues one request carrying a symbol descriptor (slot, symbol, FFT size, CP length, antenna interleave) to the downstream symbol-processing engine, using a req/ack/done handshake.
- Holds at most one pending descriptor and flags overruns.

Parameters:
- SLOT_NUM, 20, slots per frame; the slot index wraps at SLOT_NUM-1.
- SLOT_W, 5, slot index width; must satisfy 2^SLOT_W >= SLOT_NUM.
- SYM_NUM, 14, symbols per slot.

Ports:
- sys_clk  in  1  491.52 MHz clock
- sys_rst  in  1  asynchronous, active-high reset
- i_sel  in  4  rate select: 2,3 = x16 interleave, N=1024; 4,5,6 = x8, N=2048; others = x4, N=4096
- i_fram  in  1  frame-start pulse, one cycle
- o_req  out  1  descriptor valid; held until i_ack
- i_ack  in  1  engine accepts the descriptor
- i_done  in  1  engine finished the accepted symbol, one-cycle pulse
- o_slot_idx  out  SLOT_W  descriptor slot index
- o_sym_idx  out  4  descriptor symbol index
- o_fft_sel  out  2  0 = 1024, 1 = 2048, 2 = 4096
- o_cp_len  out  9  CP length in samples
- o_ant_num  out  5  antenna interleave factor: 16, 8 or 4
- o_sym_start  out  1  high on the first clock of every symbol
- o_busy  out  1  engine holds an accepted symbol
- o_ovf  out  1  sticky overrun flag
- i_ovf_clr  in  1  clears o_ovf

Behaviour:
- Reset: all outputs 0; FSM = IDLE; run = 0; pend = 0; cfg = the 4096/x4 config.
- Config latch: i_sel is decoded into cfg only on the i_fram cycle. Changes to i_sel at any other time have no effect.
- Normal CP = 72/144/288 samples; long CP = 88/176/352 samples. Long CP applies to symbol 0 of every slot.
- Symbol duration in clocks: D = (N + CP) x ant.
  - Long: 17792 for every rate.
  - Normal: 17536 for every rate.
  - The 15-bit cycle counter cnt counts 0..D-1.
- i_fram at cycle t: cnt <= 0, sym <= 0, slot <= 0, run <= 1.
  - FSM forced to IDLE; pend cleared; a pending o_req drops at t+1.
  - o_ovf is preserved.
  - i_done is ignored while IDLE.
- Boundary b = run & (cnt == 0), decoded from registers. o_sym_start = b, so the first boundary occurs at t+1.
- Counting: at cnt == D-1, cnt wraps to 0 and sym increments. After SYM_NUM-1, sym wraps to 0 and slot increments. After SLOT_NUM-1, slot wraps to 0. Timing free-runs until the next i_fram.
- Descriptor: {slot, sym, fft_sel, cp_len, ant_num} of the new symbol, captured at b. Outputs are registered and valid together with o_req.
- FSM states: IDLE, REQ, BUSY. o_req = (state == REQ); o_busy = (state == BUSY).
  - IDLE: on b, load the descriptor and go to REQ at the next cycle.
  - REQ, i_ack with no b: go to BUSY.
  - REQ, b with no i_ack: reload the output descriptor with the new symbol, set o_ovf, stay in REQ.
  - REQ, b and i_ack together: go to BUSY with the old descriptor; the new one goes into the pend slot (pend = 1).
  - BUSY, i_done: if pend = 1, move the pend descriptor to the outputs, clear pend, go to REQ. Otherwise go to IDLE.
  - BUSY, b: if pend = 0, store the new descriptor in pend. If pend = 1, overwrite it and set o_ovf.
  - BUSY, i_done and b together: b is treated as arriving after i_done. No overrun results; with pend already set, pend moves to the outputs and b refills pend.
- o_ovf: set and clear in the same cycle resolves to set.
- i_ack while not in REQ is ignored. i_done while not in BUSY is ignored.

Decomposition:
- Package pd_dw_nr_pkg holds:
  - cfg typedef {fft_sel, ant_num, cp_norm, cp_long, d_norm, d_long}
  - sel-decode function
  - CP/N constants
  - FSM state enum
- Sub-module pd_dw_nr_sym_timer: cnt/sym/slot counters and o_sym_start. The top module holds the cfg latch, the FSM and pend.

Test Plan:
- Reset, then i_fram with i_sel = 2 -> o_sym_start at t+1.
  - Next starts at t+1+17792, then every 17536.
  - o_ant_num = 16, o_fft_sel = 0, o_cp_len = 88 then 72.
  - sym 13 followed by sym 0 with slot + 1.
- i_sel = 8, engine acks 1 cycle after o_req and dones 100 cycles later -> one req per symbol; o_ovf stays 0 over 2 frames; slot wraps from 19 to 0.
- Engine never acks for 2 symbols -> o_ovf = 1; o_sym_idx shows the latest symbol; i_ovf_clr returns o_ovf to 0.
- Engine holds BUSY across 1 boundary and then dones -> o_req reasserts with the pend descriptor the cycle after done; no ovf. Across 2 boundaries -> ovf set.
- i_done coincident with b while pend = 1 -> no ovf; the old pend descriptor is issued; the new symbol lands in pend.
- i_sel changed mid-frame -> timing unchanged; the next i_fram mid-symbol resyncs to sym 0 and clears req/pend; sys_rst mid-REQ -> all outputs 0 asynchronously.
